// File: rtl/w_writeback.sv
// Writeback stage: 32x32 register file with write-first bypassed reads, registered
// commit echo, last-retired PC and free-running cycle / retired-instruction counters.
module w_writeback #(
   parameter int unsigned CNT_W    = 64,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      cw_pc,
   input  logic [4:0]       cw_write_sel,
   input  logic [31:0]      cw_result,
   input  logic             cw_is_wb,
   input  logic             cw_valid,
   input  logic [4:0]       rs1_sel,
   input  logic [4:0]       rs2_sel,
   output logic [31:0]      rs1_data,
   output logic [31:0]      rs2_data,
   output logic             wr_en,
   output logic [4:0]       wr_sel,
   output logic [31:0]      wr_data,
   output logic [31:0]      w_last_pc,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned NREGS  = 32;

   logic [XLEN-1:0]   regs_q [NREGS];
   logic              we_c;

   logic              wr_en_q,   wr_en_d;
   logic [REG_AW-1:0] wr_sel_q,  wr_sel_d;
   logic [XLEN-1:0]   wr_data_q, wr_data_d;
   logic [XLEN-1:0]   last_pc_q, last_pc_d;
   logic [CNT_W-1:0]  cycle_q,   cycle_d;
   logic [CNT_W-1:0]  instret_q, instret_d;

   // A commit needs a real instruction that writes a non-zero destination.
   assign we_c = cw_valid & cw_is_wb & (cw_write_sel != REG_AW'(0));

   function automatic logic [XLEN-1:0] read_port(input logic [REG_AW-1:0] sel);
      logic [XLEN-1:0] data;
      data = regs_q[sel];
      if (sel == REG_AW'(0)) begin
         data = XLEN'(0);
      end else if (we_c && (sel == cw_write_sel)) begin
         data = cw_result;
      end
      return data;
   endfunction

   always_comb begin
      rs1_data = XLEN'(0);
      rs2_data = XLEN'(0);
      rs1_data = read_port(rs1_sel);
      rs2_data = read_port(rs2_sel);
   end

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= XLEN'(0);
         end
      end else if (we_c) begin
         regs_q[cw_write_sel] <= cw_result;
      end
   end

   always_comb begin
      wr_en_d   = we_c;
      wr_sel_d  = cw_write_sel;
      wr_data_d = cw_result;
      last_pc_d = last_pc_q;
      instret_d = instret_q;
      cycle_d   = cycle_q + CNT_W'(1);
      if (cw_valid) begin
         last_pc_d = cw_pc;
         instret_d = instret_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_en_q   <= 1'b0;
         wr_sel_q  <= REG_AW'(0);
         wr_data_q <= XLEN'(0);
         last_pc_q <= RESET_PC;
         cycle_q   <= CNT_W'(0);
         instret_q <= CNT_W'(0);
      end else begin
         wr_en_q   <= wr_en_d;
         wr_sel_q  <= wr_sel_d;
         wr_data_q <= wr_data_d;
         last_pc_q <= last_pc_d;
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_sel      = wr_sel_q;
   assign wr_data     = wr_data_q;
   assign w_last_pc   = last_pc_q;
   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;

endmodule

// File: tb/tb_w_writeback.sv
// Directed and random bench for w_writeback with a reference register-file model
// and a queue of expected commit echoes.
`timescale 1ns/1ps
module tb_w_writeback;

   localparam int unsigned CNT_W    = 8;
   localparam logic [31:0] RESET_PC = 32'hA000_0100;

   logic             clock;
   logic             reset;
   logic [31:0]      cw_pc;
   logic [4:0]       cw_write_sel;
   logic [31:0]      cw_result;
   logic             cw_is_wb;
   logic             cw_valid;
   logic [4:0]       rs1_sel;
   logic [4:0]       rs2_sel;
   logic [31:0]      rs1_data;
   logic [31:0]      rs2_data;
   logic             wr_en;
   logic [4:0]       wr_sel;
   logic [31:0]      wr_data;
   logic [31:0]      w_last_pc;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instret_cnt;

   w_writeback #(.CNT_W(CNT_W), .RESET_PC(RESET_PC)) dut (
      .clock(clock), .reset(reset), .cw_pc(cw_pc), .cw_write_sel(cw_write_sel),
      .cw_result(cw_result), .cw_is_wb(cw_is_wb), .cw_valid(cw_valid),
      .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .w_last_pc(w_last_pc),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic        en;
      logic [4:0]  sel;
      logic [31:0] data;
   } wr_exp_t;

   wr_exp_t          sb_q [$];
   logic [31:0]      m_regs [32];
   logic [CNT_W-1:0] m_cyc;
   logic [CNT_W-1:0] m_inst;
   logic [31:0]      m_pc;
   int               n_checks = 0;
   int               n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cyc  = '0;
      m_inst = '0;
      m_pc   = RESET_PC;
      sb_q.delete();
   endtask

   function automatic logic [31:0] exp_read(input logic [4:0] sel, input logic we,
                                            input logic [4:0] wsel, input logic [31:0] res);
      if (sel == 5'd0) return 32'h0;
      if (we === 1'b1 && sel == wsel) return res;
      return m_regs[sel];
   endfunction

   // One pipeline beat: drive, check bypassed reads, clock, check registered state.
   task automatic step(input logic v, input logic wb, input logic [4:0] sel,
                       input logic [31:0] res, input logic [31:0] pc,
                       input logic [4:0] r1, input logic [4:0] r2);
      logic    we;
      wr_exp_t e;
      cw_valid = v; cw_is_wb = wb; cw_write_sel = sel; cw_result = res; cw_pc = pc;
      rs1_sel = r1; rs2_sel = r2;
      we = v & wb & (sel != 5'd0);
      #1;
      chk("rs1_read", 64'(rs1_data), 64'(exp_read(r1, we, sel, res)));
      chk("rs2_read", 64'(rs2_data), 64'(exp_read(r2, we, sel, res)));
      e.en = (we === 1'b1); e.sel = sel; e.data = res;
      sb_q.push_back(e);
      @(posedge clock);
      if (we === 1'b1) m_regs[sel] = res;
      if (v === 1'b1) begin
         m_pc   = pc;
         m_inst = m_inst + 1'b1;
      end
      m_cyc = m_cyc + 1'b1;
      #1;
      e = sb_q.pop_front();
      chk("wr_en", 64'(wr_en), 64'(e.en));
      if (e.en) begin
         chk("wr_sel", 64'(wr_sel), 64'(e.sel));
         chk("wr_data", 64'(wr_data), 64'(e.data));
      end
      chk("w_last_pc", 64'(w_last_pc), 64'(m_pc));
      chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
      chk("instret_cnt", 64'(instret_cnt), 64'(m_inst));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      cw_valid = 1'b0; cw_is_wb = 1'b0; cw_write_sel = 5'd0; cw_result = 32'h0;
      cw_pc = 32'h0; rs1_sel = 5'd1; rs2_sel = 5'd2;
      model_reset();

      // Reset state before any clock edge.
      #3;
      chk("rst_wr_en", 64'(wr_en), 64'h0);
      chk("rst_wr_sel", 64'(wr_sel), 64'h0);
      chk("rst_wr_data", 64'(wr_data), 64'h0);
      chk("rst_last_pc", 64'(w_last_pc), 64'(RESET_PC));
      chk("rst_cycle", 64'(cycle_cnt), 64'h0);
      chk("rst_instret", 64'(instret_cnt), 64'h0);

      // A commit presented while reset is held must not land.
      cw_valid = 1'b1; cw_is_wb = 1'b1; cw_write_sel = 5'd3; cw_result = 32'h55;
      repeat (3) @(posedge clock);
      #1;
      chk("hold_wr_en", 64'(wr_en), 64'h0);
      chk("hold_cycle", 64'(cycle_cnt), 64'h0);
      chk("hold_instret", 64'(instret_cnt), 64'h0);

      // Reset asserted in the same cycle as a write wins over the write.
      @(negedge clock);
      reset = 1'b0;
      cw_write_sel = 5'd7; cw_result = 32'hCAFE_0007; cw_pc = 32'h44;
      #2 reset = 1'b1;
      @(posedge clock);
      #1;
      chk("midwr_wr_en", 64'(wr_en), 64'h0);
      chk("midwr_cycle", 64'(cycle_cnt), 64'h0);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd3);

      // Bypass then storage read of x5.
      step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h40, 5'd5, 5'd0);
      step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5);
      chk("x5_storage", 64'(rs1_data), 64'hDEAD_BEEF);

      // Writes to x0 are dropped and never visible.
      step(1'b1, 1'b1, 5'd0, 32'h1234, 32'h48, 5'd0, 5'd0);
      step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);

      // Retirement accounting across a bubble and a store.
      begin
         logic [CNT_W-1:0] c0, i0;
         c0 = m_cyc; i0 = m_inst;
         step(1'b1, 1'b1, 5'd9,  32'h0000_0009, 32'h100, 5'd9, 5'd10);
         step(1'b0, 1'b1, 5'd10, 32'hBAD0_BAD0, 32'h999, 5'd10, 5'd9);
         step(1'b1, 1'b1, 5'd10, 32'h0000_000A, 32'h104, 5'd9, 5'd10);
         step(1'b1, 1'b0, 5'd11, 32'h0000_000B, 32'h108, 5'd11, 5'd10);
         chk("seq_instret", 64'(instret_cnt - i0), 64'd3);
         chk("seq_cycle", 64'(cycle_cnt - c0), 64'd4);
         chk("seq_last_pc", 64'(w_last_pc), 64'h108);
      end

      // Writing one register leaves the other port's register undisturbed.
      step(1'b1, 1'b1, 5'd12, 32'h1212_1212, 32'h10C, 5'd9, 5'd12);

      // X on every field of a bubble must not reach state.
      step(1'b0, 1'bx, 5'bxxxxx, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 5'd9, 5'd12);

      // Counter wrap (narrow counters in this bench).
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 1'b0, 5'd0, 32'h0, 32'h2000 + 32'(i * 4), 5'd5, 5'd9);
         if (m_inst == '0) chk("instret_wrap", 64'(instret_cnt), 64'h0);
      end

      // Random traffic against the reference model.
      for (int i = 0; i < 10000; i++) begin
         logic [4:0] s, a, b;
         s = 5'($urandom_range(0, 31));
         a = ($urandom_range(0, 3) == 0) ? s : 5'($urandom_range(0, 31));
         b = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), s, $urandom,
              $urandom, a, b);
      end

      // Fill x1..x31, then reset between edges.
      for (int i = 1; i < 32; i++) begin
         step(1'b1, 1'b1, 5'(i), 32'(i * 32'h11), 32'h3000 + 32'(i), 5'(i), 5'(32 - i));
      end
      cw_valid = 1'b0; cw_is_wb = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("pulse_cycle", 64'(cycle_cnt), 64'h0);
      chk("pulse_instret", 64'(instret_cnt), 64'h0);
      chk("pulse_last_pc", 64'(w_last_pc), 64'(RESET_PC));
      chk("pulse_wr_en", 64'(wr_en), 64'h0);
      chk("pulse_wr_data", 64'(wr_data), 64'h0);
      for (int i = 1; i < 32; i++) begin
         rs1_sel = 5'(i); rs2_sel = 5'(32 - i);
         #1;
         chk("pulse_rs1", 64'(rs1_data), 64'h0);
         chk("pulse_rs2", 64'(rs2_data), 64'h0);
      end
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd31, 5'd17);
      chk("post_rst_cycle", 64'(cycle_cnt), 64'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/w_writeback.md
W_WRITEBACK -- requirements
Module: w_writeback

Interface
REQ-001 Parameter CNT_W, default 64: width of the cycle and retired-instruction counters.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: reset value of w_last_pc.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clock.
REQ-005 cw_pc  input  32  PC of the instruction leaving the memory stage.
REQ-006 cw_write_sel  input  5  destination register index.
REQ-007 cw_result  input  32  load data or ALU result to write back.
REQ-008 cw_is_wb  input  1  instruction writes a destination register.
REQ-009 cw_valid  input  1  1 = real instruction; 0 = bubble (the memory stage's reset values form a bubble).
REQ-010 rs1_sel, rs2_sel  input  5 each  decode-stage read addresses.
REQ-011 rs1_data, rs2_data  output  32 each  combinational read data.
REQ-012 wr_en  output  1  registered: a write committed last cycle.
REQ-013 wr_sel / wr_data  output  5 / 32  registered index and data of that write.
REQ-014 w_last_pc  output  32  registered PC of the most recently retired instruction.
REQ-015 cycle_cnt, instret_cnt  output  CNT_W each  free-running cycle count and retired-instruction count.

Function
REQ-016 The block SHALL hold 32 x 32-bit architectural registers, x1..x31 writable; x0 is hard-wired to 0 and has no storage write.
REQ-017 Commit condition: we = cw_valid & cw_is_wb & (cw_write_sel != 0); on a rising edge with we=1, reg[cw_write_sel] <= cw_result.
REQ-018 The write SHALL be visible through a normal read in the cycle after the edge (one-cycle write latency).
REQ-019 Read ports SHALL be write-first bypassed: if we=1 and rsN_sel == cw_write_sel, then rsN_data = cw_result in that same cycle.
REQ-020 rsN_sel == 0 SHALL return 0, even when cw_write_sel == 0 and cw_is_wb=1.
REQ-021 Both read ports SHALL be independent; equal addresses return identical data, including under bypass.
REQ-022 Each edge: wr_en <= we, wr_sel <= cw_write_sel, wr_data <= cw_result; wr_sel and wr_data are don't-care when wr_en=0 but SHALL still update.
REQ-023 w_last_pc SHALL update to cw_pc only on edges with cw_valid=1, and SHALL hold otherwise.
REQ-024 instret_cnt SHALL increment by 1 on every edge with cw_valid=1, regardless of cw_is_wb; bubbles do not count.
REQ-025 cycle_cnt SHALL increment by 1 on every edge while reset is low.
REQ-026 Both counters SHALL wrap modulo 2^CNT_W (all-ones + 1 -> 0) with no flag and no saturation.
REQ-027 A write to the register currently being read with a different index on the other port SHALL not disturb that port.
REQ-028 Inputs X while cw_valid=0 SHALL not corrupt any state.

Reset
REQ-029 On reset assertion, all of the following SHALL clear asynchronously, mid-cycle, with no dependence on a clock edge:
- reg[1..31] = 0
- wr_en = 0, wr_sel = 0, wr_data = 0
- w_last_pc = RESET_PC
- cycle_cnt = 0, instret_cnt = 0
REQ-030 While reset is high, no commit SHALL occur, even with we=1 and the clock running.
REQ-031 The first edge after reset deasserts SHALL be a normal operating edge; cycle_cnt reads 1 after it.
REQ-032 Reset asserted mid-write (same cycle as we=1) SHALL win; the target register reads 0 afterward.

Verification
REQ-033 Write x5 = 0xDEADBEEF (valid, is_wb), with rs1_sel = 5 in the same cycle -> rs1_data = 0xDEADBEEF before the edge (bypass); after the edge rs1_data = 0xDEADBEEF from storage, wr_en = 1, wr_sel = 5.
REQ-034 Write x0 = 0x1234 with rs1_sel = rs2_sel = 0 -> rs1_data = rs2_data = 0 in the write cycle and after; wr_en = 0 after the edge.
REQ-035 Three valid instructions (PCs 0x100, 0x104, 0x108), one bubble between them, and one non-wb store -> instret_cnt = 3, w_last_pc = 0x108, cycle_cnt = 4 after the four edges.
REQ-036 Preload instret_cnt = 2^64 - 1 (or run with CNT_W = 4 to 15), then one valid instruction -> instret_cnt = 0.
REQ-037 Fill x1..x31 with index*0x11, then pulse reset between edges -> all reads return 0 immediately, all counters = 0, w_last_pc = RESET_PC, with no clock edge needed.
REQ-038 Random mix of writes and reads on both ports compared against a reference register-file model, 10k cycles -> zero mismatches.
